// File: rtl/fpu_instr_issue_queue.sv
// Instruction issue queue in front of decode: buffers host-written words and holds
// FP instructions until fpu_complete. Optional perf counters: FPU_ISSUE_PERF_CNT_EN.
module fpu_instr_issue_queue #(
    parameter int DEPTH        = 8,
    parameter int PTR_W        = 3,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             wr_valid,
    input  logic [31:0]      wr_data,
    output logic             wr_ready,
    input  logic             flush,
    input  logic             halt_req,
    input  logic             fpu_complete,
    output logic [31:0]      Instruction,
    output logic             fpu_active,
    output logic [PTR_W:0]   q_count,
    output logic             q_empty,
    output logic             timeout_err,
    output logic [1:0]       state_dbg
`ifdef FPU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [7:0]       WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t             state, state_d;
    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [31:0]        head, instr_d;
    logic [7:0]         wait_cnt, cnt_d;
    logic               active_d, timeout_set, push, pop;

    function automatic logic is_fp(input logic [6:0] opc);
        case (opc)
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011,
            7'b1001111, 7'b0000111, 7'b0100111: is_fp = 1'b1;
            default:                             is_fp = 1'b0;
        endcase
    endfunction

    // Write handshake: a word transfers on a rising edge where wr_valid && wr_ready;
    // wr_ready depends only on occupancy, and a flush in the same cycle discards it.
    assign wr_ready  = (q_count != FULL_CNT);
    assign q_empty   = (q_count == '0);
    assign push      = wr_valid & wr_ready & ~flush;
    assign head      = mem[rd_ptr];
    assign state_dbg = state;

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      q_count <= q_count + CNT_ONE;
            else if (!push && pop) q_count <= q_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state       <= IDLE;
            Instruction <= '0;
            fpu_active  <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            Instruction <= instr_d;
            fpu_active  <= active_d;
            wait_cnt    <= cnt_d;
            if (timeout_set) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state;
        instr_d     = Instruction;
        active_d    = fpu_active;
        cnt_d       = wait_cnt;
        timeout_set = 1'b0;
        pop         = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            instr_d  = '0;
            active_d = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state)
                IDLE: begin
                    instr_d  = '0;
                    active_d = 1'b0;
                    cnt_d    = '0;
                    if (!q_empty && !halt_req) begin
                        pop     = 1'b1;
                        instr_d = head;
                        if (is_fp(head[6:0])) begin
                            state_d  = WAIT;
                            active_d = 1'b1;
                        end else begin
                            state_d  = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_d  = IDLE;
                    instr_d  = '0;
                    active_d = 1'b0;
                end
                WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (fpu_complete) begin
                        state_d = DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_d     = IDLE;
                        instr_d     = '0;
                        active_d    = 1'b0;
                        cnt_d       = '0;
                        timeout_set = 1'b1;
                    end else begin
                        cnt_d = wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    instr_d  = '0;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef FPU_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (pop) perf_issued <= perf_issued + 32'd1;
            if (state == WAIT || (state == IDLE && !q_empty && halt_req))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_instr_issue_queue.sv
// Directed bench for fpu_instr_issue_queue: inputs driven and outputs sampled on negedge.
module tb_fpu_instr_issue_queue;
    logic        clk, rst_l, wr_valid, flush, halt_req, fpu_complete;
    logic [31:0] wr_data;
    logic        wr_ready, fpu_active, q_empty, timeout_err;
    logic [31:0] Instruction;
    logic [3:0]  q_count;
    logic [1:0]  state_dbg;
`ifdef FPU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LUI  = 32'h123450B7;
    localparam logic [31:0] FADD = 32'h00208053;
    localparam logic [31:0] FLW  = 32'h00012087;
    localparam logic [31:0] ADD2 = 32'h00700093;
    localparam logic [31:0] FMAD = 32'h18208043;

    fpu_instr_issue_queue #(.DEPTH(8), .PTR_W(3), .WAIT_TIMEOUT(255)) dut (
        .clk(clk), .rst_l(rst_l), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .flush(flush), .halt_req(halt_req),
        .fpu_complete(fpu_complete), .Instruction(Instruction),
        .fpu_active(fpu_active), .q_count(q_count), .q_empty(q_empty),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
`ifdef FPU_ISSUE_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks (called at a negedge, return at the next negedge)
    task automatic push_word(input logic [31:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_data  = '0;
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (Instruction != 32'h0) break;
        end
        chk(tag, Instruction, exp);
    endtask

    initial begin
        rst_l = 1'b0; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
        halt_req = 1'b0; fpu_complete = 1'b0;
        #3;
        chk("rst_instr",   Instruction, 32'h0);
        chk("rst_active",  32'(fpu_active), 32'd0);
        chk("rst_count",   32'(q_count), 32'd0);
        chk("rst_empty",   32'(q_empty), 32'd1);
        chk("rst_ready",   32'(wr_ready), 32'd1);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_state",   32'(state_dbg), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;

        // two non-FP words: one cycle each with a zero cycle between
        halt_req = 1'b1;
        push_word(ADDI);
        push_word(LUI);
        chk("nfp_count2", 32'(q_count), 32'd2);
        halt_req = 1'b0;
        @(negedge clk);
        chk("nfp_addi", Instruction, ADDI);
        chk("nfp_active", 32'(fpu_active), 32'd0);
        @(negedge clk);
        chk("nfp_gap", Instruction, 32'h0);
        @(negedge clk);
        chk("nfp_lui", Instruction, LUI);
        chk("nfp_count0", 32'(q_count), 32'd0);
        @(negedge clk);
        chk("nfp_idle", Instruction, 32'h0);

        // FP word with fpu_complete after 5 WAIT cycles: 7 active cycles total
        push_word(FADD);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("fp_active", 32'(fpu_active), 32'd1);
            chk("fp_hold", Instruction, FADD);
            if (i == 5) fpu_complete = 1'b1;
            if (i == 6) fpu_complete = 1'b0;
        end
        @(negedge clk);
        chk("fp_end_active", 32'(fpu_active), 32'd0);
        chk("fp_end_instr", Instruction, 32'h0);
        chk("fp_end_state", 32'(state_dbg), 32'd0);

        // fill 8 under halt, 9th dropped, then drain in order across pointer wrap
        halt_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back({12'(i + 1), 20'h00093});
            push_word({12'(i + 1), 20'h00093});
            if (i == 7) begin
                chk("full_ready", 32'(wr_ready), 32'd0);
                chk("full_count", 32'(q_count), 32'd8);
            end
        end
        chk("drop_count", 32'(q_count), 32'd8);
        halt_req = 1'b0;
        while (exp_q.size() > 0) expect_issue("fifo_order", exp_q.pop_front());
        chk("drain_empty", 32'(q_empty), 32'd1);
        @(negedge clk);

        // FP word never completes: timeout after 255 WAIT cycles, next word issues
        halt_req = 1'b1;
        push_word(FLW);
        push_word(ADD2);
        halt_req = 1'b0;
        expect_issue("to_issue", FLW);
        repeat (254) @(negedge clk);
        chk("to_last_active", 32'(fpu_active), 32'd1);
        chk("to_last_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        chk("to_active", 32'(fpu_active), 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_instr", Instruction, 32'h0);
        expect_issue("to_next", ADD2);
        @(negedge clk);

        // flush during WAIT with 3 words queued
        halt_req = 1'b1;
        push_word(FMAD);
        push_word(ADDI);
        push_word(LUI);
        push_word(ADD2);
        halt_req = 1'b0;
        expect_issue("fl_issue", FMAD);
        chk("fl_count3", 32'(q_count), 32'd3);
        halt_req = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_instr", Instruction, 32'h0);
        chk("fl_active", 32'(fpu_active), 32'd0);
        chk("fl_empty", 32'(q_empty), 32'd1);
        chk("fl_err_sticky", 32'(timeout_err), 32'd1);

        // flush and write together: write dropped
        flush = 1'b1;
        wr_valid = 1'b1;
        wr_data = ADDI;
        @(negedge clk);
        flush = 1'b0;
        wr_valid = 1'b0;
        chk("fl_wr_drop", 32'(q_count), 32'd0);

        // asynchronous reset mid-WAIT
        push_word(FLW);
        push_word(ADDI);
        halt_req = 1'b0;
        expect_issue("ar_issue", FLW);
        chk("ar_pre_count", 32'(q_count), 32'd1);
        #2 rst_l = 1'b0;
        #1;
        chk("ar_instr",   Instruction, 32'h0);
        chk("ar_active",  32'(fpu_active), 32'd0);
        chk("ar_count",   32'(q_count), 32'd0);
        chk("ar_empty",   32'(q_empty), 32'd1);
        chk("ar_ready",   32'(wr_ready), 32'd1);
        chk("ar_timeout", 32'(timeout_err), 32'd0);
        chk("ar_state",   32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;

        // stray fpu_complete in IDLE is ignored
        fpu_complete = 1'b1;
        @(negedge clk);
        fpu_complete = 1'b0;
        chk("stray_state", 32'(state_dbg), 32'd0);
        chk("stray_active", 32'(fpu_active), 32'd0);

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
